// File: rtl/sic_pkg.sv
// Shared types and constants for the per-SIC register sequencer.
package sic_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_RS    = 3'd1,
      S_REL_RS   = 3'd2,
      S_RD_RT    = 3'd3,
      S_REL_RT   = 3'd4,
      S_WAIT_RES = 3'd5,
      S_WR       = 3'd6,
      S_REL_WR   = 3'd7
   } sic_seq_state_e;

   localparam int unsigned REG_ZERO_ADDR = 0;

endpackage

// File: rtl/sic_reg_sequencer.sv
// Operand/result sequencer between one SIC and its locked register-file port.
// Reads sources under lock with release, presents operands, writes the result back under lock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready; latch command on cmd_valid
// RD_RS      | read-lock request for rs, capture data on grant
// REL_RS     | one-cycle release of rs lock
// RD_RT      | read-lock request for rt, capture data on grant
// REL_RT     | one-cycle release of rt lock
// WAIT_RES   | operands valid, wait for execution result
// WR         | write-lock request for rd with latched result
// REL_WR     | one-cycle release of rd lock, instruction done
module sic_reg_sequencer
   import sic_pkg::*;
#(
   parameter int NUM_PHY_REGS = 32,
   parameter int ID_WIDTH     = 8,
   localparam int AW          = $clog2(NUM_PHY_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ID_WIDTH-1:0] cmd_issue_id,
   input  logic                cmd_rs_en,
   input  logic [AW-1:0]       cmd_rs_addr,
   input  logic                cmd_rt_en,
   input  logic [AW-1:0]       cmd_rt_addr,
   input  logic                cmd_rd_en,
   input  logic [AW-1:0]       cmd_rd_addr,
   output logic                opnd_valid,
   output logic [31:0]         opnd_rs_data,
   output logic [31:0]         opnd_rt_data,
   input  logic                res_valid,
   input  logic [31:0]         res_data,
   output logic                res_ready,
   output logic                done,
   output logic [AW-1:0]       sic_addr,
   output logic                sic_req_read,
   output logic                sic_req_write,
   output logic [ID_WIDTH-1:0] sic_issue_id,
   output logic                sic_release,
   output logic [31:0]         sic_wdata,
   input  logic [31:0]         sic_rdata,
   input  logic                sic_grant
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO_ADDR);

   sic_seq_state_e      state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [AW-1:0]       rs_addr_q, rs_addr_d;
   logic [AW-1:0]       rt_addr_q, rt_addr_d;
   logic [AW-1:0]       rd_addr_q, rd_addr_d;
   logic                rs_need_q, rs_need_d;
   logic                rt_need_q, rt_need_d;
   logic                rd_en_q, rd_en_d;
   logic [31:0]         rs_data_q, rs_data_d;
   logic [31:0]         rt_data_q, rt_data_d;
   logic [31:0]         res_q, res_d;

   logic                new_rs_need, new_rt_need;

   // Register 0 reads as zero without ever touching the lock.
   assign new_rs_need = cmd_rs_en && (cmd_rs_addr != ZERO_ADDR);
   assign new_rt_need = cmd_rt_en && (cmd_rt_addr != ZERO_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
         rs_need_q <= 1'b0;
         rt_need_q <= 1'b0;
         rd_en_q   <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         rd_addr_q <= rd_addr_d;
         rs_need_q <= rs_need_d;
         rt_need_q <= rt_need_d;
         rd_en_q   <= rd_en_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         res_q     <= res_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      rs_addr_d     = rs_addr_q;
      rt_addr_d     = rt_addr_q;
      rd_addr_d     = rd_addr_q;
      rs_need_d     = rs_need_q;
      rt_need_d     = rt_need_q;
      rd_en_d       = rd_en_q;
      rs_data_d     = rs_data_q;
      rt_data_d     = rt_data_q;
      res_d         = res_q;
      cmd_ready     = 1'b0;
      opnd_valid    = 1'b0;
      res_ready     = 1'b0;
      done          = 1'b0;
      sic_addr      = '0;
      sic_req_read  = 1'b0;
      sic_req_write = 1'b0;
      sic_issue_id  = '0;
      sic_release   = 1'b0;
      sic_wdata     = '0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               id_d      = cmd_issue_id;
               rs_addr_d = cmd_rs_addr;
               rt_addr_d = cmd_rt_addr;
               rd_addr_d = cmd_rd_addr;
               rs_need_d = new_rs_need;
               rt_need_d = new_rt_need;
               rd_en_d   = cmd_rd_en && (cmd_rd_addr != ZERO_ADDR);
               rs_data_d = '0;
               rt_data_d = '0;
               res_d     = '0;
               if (new_rs_need)
                  state_d = S_RD_RS;
               else if (new_rt_need)
                  state_d = S_RD_RT;
               else
                  state_d = S_WAIT_RES;
            end
         end

         S_RD_RS: begin
            sic_addr     = rs_addr_q;
            sic_req_read = 1'b1;
            sic_issue_id = id_q;
            if (sic_grant) begin
               rs_data_d = sic_rdata;
               state_d   = S_REL_RS;
            end
         end

         S_REL_RS: begin
            sic_addr     = rs_addr_q;
            sic_release  = 1'b1;
            sic_issue_id = id_q;
            state_d      = rt_need_q ? S_RD_RT : S_WAIT_RES;
         end

         S_RD_RT: begin
            sic_addr     = rt_addr_q;
            sic_req_read = 1'b1;
            sic_issue_id = id_q;
            if (sic_grant) begin
               rt_data_d = sic_rdata;
               state_d   = S_REL_RT;
            end
         end

         S_REL_RT: begin
            sic_addr     = rt_addr_q;
            sic_release  = 1'b1;
            sic_issue_id = id_q;
            state_d      = S_WAIT_RES;
         end

         S_WAIT_RES: begin
            opnd_valid = 1'b1;
            res_ready  = 1'b1;
            if (res_valid) begin
               res_d = res_data;
               if (rd_en_q) begin
                  state_d = S_WR;
               end else begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         S_WR: begin
            sic_addr      = rd_addr_q;
            sic_req_write = 1'b1;
            sic_wdata     = res_q;
            sic_issue_id  = id_q;
            if (sic_grant)
               state_d = S_REL_WR;
         end

         S_REL_WR: begin
            sic_addr     = rd_addr_q;
            sic_release  = 1'b1;
            sic_issue_id = id_q;
            done         = 1'b1;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign opnd_rs_data = rs_data_q;
   assign opnd_rt_data = rt_data_q;

endmodule

// File: tb/tb_sic_reg_sequencer.sv
// Directed bench for sic_reg_sequencer with a behavioural locked register-file port.
module tb_sic_reg_sequencer;

   localparam int AW = 5;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] cmd_issue_id;
   logic          cmd_rs_en, cmd_rt_en, cmd_rd_en;
   logic [AW-1:0] cmd_rs_addr, cmd_rt_addr, cmd_rd_addr;
   logic          opnd_valid;
   logic [31:0]   opnd_rs_data, opnd_rt_data;
   logic          res_valid;
   logic [31:0]   res_data;
   logic          res_ready;
   logic          done;
   logic [AW-1:0] sic_addr;
   logic          sic_req_read, sic_req_write;
   logic [IW-1:0] sic_issue_id;
   logic          sic_release;
   logic [31:0]   sic_wdata;
   logic [31:0]   sic_rdata;
   logic          sic_grant;

   logic          grant_en;
   logic [31:0]   regs [32];
   int            rd_count, wr_count, rel_count;
   logic [AW-1:0] last_wr_addr;
   logic [31:0]   last_wr_data;

   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   sic_reg_sequencer #(.NUM_PHY_REGS(32), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_issue_id(cmd_issue_id),
      .cmd_rs_en(cmd_rs_en), .cmd_rs_addr(cmd_rs_addr),
      .cmd_rt_en(cmd_rt_en), .cmd_rt_addr(cmd_rt_addr),
      .cmd_rd_en(cmd_rd_en), .cmd_rd_addr(cmd_rd_addr),
      .opnd_valid(opnd_valid), .opnd_rs_data(opnd_rs_data), .opnd_rt_data(opnd_rt_data),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .done(done),
      .sic_addr(sic_addr), .sic_req_read(sic_req_read), .sic_req_write(sic_req_write),
      .sic_issue_id(sic_issue_id), .sic_release(sic_release), .sic_wdata(sic_wdata),
      .sic_rdata(sic_rdata), .sic_grant(sic_grant)
   );

   // Port model: grant is combinational on any request; read data only with a granted read.
   assign sic_grant = grant_en && (sic_req_read || sic_req_write);
   assign sic_rdata = (sic_grant && sic_req_read) ? regs[sic_addr] : 32'h0;

   always @(posedge clk) begin
      if (!rst && sic_grant && sic_req_read)
         rd_count <= rd_count + 1;
      if (!rst && sic_grant && sic_req_write) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= sic_addr;
         last_wr_data <= sic_wdata;
      end
      if (sic_release)
         rel_count <= rel_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [IW-1:0] id,
                           input logic rse, input logic [AW-1:0] rsa,
                           input logic rte, input logic [AW-1:0] rta,
                           input logic rde, input logic [AW-1:0] rda);
      cmd_valid    = 1'b1;
      cmd_issue_id = id;
      cmd_rs_en = rse; cmd_rs_addr = rsa;
      cmd_rt_en = rte; cmd_rt_addr = rta;
      cmd_rd_en = rde; cmd_rd_addr = rda;
   endtask

   initial begin
      int base_rd, base_wr, base_rel;
      rst = 1'b1; cmd_valid = 1'b0; cmd_issue_id = '0;
      cmd_rs_en = 1'b0; cmd_rt_en = 1'b0; cmd_rd_en = 1'b0;
      cmd_rs_addr = '0; cmd_rt_addr = '0; cmd_rd_addr = '0;
      res_valid = 1'b0; res_data = '0; grant_en = 1'b1;
      rd_count = 0; wr_count = 0; rel_count = 0;
      last_wr_addr = '0; last_wr_data = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
      regs[3] = 32'hA; regs[5] = 32'hB; regs[4] = 32'h44;
      regs[9] = 32'h99; regs[6] = 32'h66;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_outs", {opnd_valid, res_ready, done, sic_req_read, sic_req_write, sic_release}, 0);
      chk("reset_buses", {sic_addr, sic_issue_id, sic_wdata}, 0);
      chk("reset_opnd", opnd_rs_data | opnd_rt_data, 0);

      // Best case: rs=3, rt=5, rd=7, immediate grants
      send_cmd(8'h12, 1, 5'd3, 1, 5'd5, 1, 5'd7);
      @(negedge clk); cmd_valid = 1'b0;
      chk("t1_rdrs", {sic_req_read, sic_req_write, sic_release, cmd_ready}, 4'b1000);
      chk("t1_rdrs_addr", sic_addr, 3);
      chk("t1_rdrs_id", sic_issue_id, 8'h12);
      @(negedge clk);
      chk("t1_relrs", {sic_req_read, sic_release}, 2'b01);
      chk("t1_relrs_addr", sic_addr, 3);
      chk("t1_rs_cap", opnd_rs_data, 32'hA);
      @(negedge clk);
      chk("t1_rdrt", {sic_req_read, sic_addr}, {1'b1, 5'd5});
      @(negedge clk);
      chk("t1_relrt", {sic_release, sic_addr}, {1'b1, 5'd5});
      @(negedge clk);
      chk("t1_opnd_valid", {opnd_valid, res_ready}, 2'b11);
      chk("t1_opnd", {opnd_rs_data, opnd_rt_data}, {32'hA, 32'hB});
      res_valid = 1'b1; res_data = 32'h15;
      #1 chk("t1_no_done_wait", done, 0);
      @(negedge clk); res_valid = 1'b0;
      chk("t1_wr", {sic_req_write, sic_req_read, sic_addr}, {1'b1, 1'b0, 5'd7});
      chk("t1_wdata", sic_wdata, 32'h15);
      chk("t1_wr_nores", {res_ready, opnd_valid}, 0);
      @(negedge clk);
      chk("t1_relwr", {sic_release, done, sic_req_write, sic_addr}, {1'b1, 1'b1, 1'b0, 5'd7});
      chk("t1_wr_log", {last_wr_addr, last_wr_data}, {5'd7, 32'h15});
      @(negedge clk);
      chk("t1_idle", {cmd_ready, done, sic_release}, 3'b100);
      chk("t1_counts", {rd_count[7:0], wr_count[7:0], rel_count[7:0]}, {8'd2, 8'd1, 8'd3});

      // rs=4 with grant withheld 6 cycles, no rt, no rd
      grant_en = 1'b0;
      send_cmd(8'h21, 1, 5'd4, 0, 5'd0, 0, 5'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); cmd_valid = 1'b0;
         chk("t2_stall_req", {sic_req_read, sic_release, sic_addr}, {1'b1, 1'b0, 5'd4});
         chk("t2_stall_nocap", opnd_rs_data, 0);
      end
      grant_en = 1'b1;
      @(negedge clk);
      chk("t2_rel", {sic_release, sic_addr}, {1'b1, 5'd4});
      chk("t2_cap", opnd_rs_data, 32'h44);
      @(negedge clk);
      chk("t2_wait", {opnd_valid, opnd_rt_data}, {1'b1, 32'h0});
      res_valid = 1'b1; res_data = 32'hDEAD;
      #1 chk("t2_done", done, 1);
      @(negedge clk); res_valid = 1'b0;
      chk("t2_idle", {cmd_ready, done, sic_req_write}, 3'b100);

      // rs=0 (hard zero), rt=9, rd=0 (no write)
      base_rd = rd_count; base_wr = wr_count;
      send_cmd(8'h33, 1, 5'd0, 1, 5'd9, 1, 5'd0);
      @(negedge clk); cmd_valid = 1'b0;
      chk("t3_rd9", {sic_req_read, sic_addr}, {1'b1, 5'd9});
      @(negedge clk);
      chk("t3_rel9", {sic_release, sic_addr}, {1'b1, 5'd9});
      @(negedge clk);
      chk("t3_opnd", {opnd_valid, opnd_rs_data, opnd_rt_data}, {1'b1, 32'h0, 32'h99});
      res_valid = 1'b1; res_data = 32'h1234;
      #1 chk("t3_done", done, 1);
      @(negedge clk); res_valid = 1'b0;
      chk("t3_idle", cmd_ready, 1);
      chk("t3_counts", {rd_count - base_rd, wr_count - base_wr}, {32'd1, 32'd0});

      // rs=rt=6 read twice, rd=2, then write grant stalled 4 cycles
      base_rd = rd_count;
      send_cmd(8'h44, 1, 5'd6, 1, 5'd6, 1, 5'd2);
      @(negedge clk); cmd_valid = 1'b0;
      chk("t4_rd1", {sic_req_read, sic_addr}, {1'b1, 5'd6});
      @(negedge clk);
      chk("t4_rel1", {sic_release, sic_addr}, {1'b1, 5'd6});
      @(negedge clk);
      chk("t4_rd2", {sic_req_read, sic_addr}, {1'b1, 5'd6});
      @(negedge clk);
      chk("t4_rel2", {sic_release, sic_addr}, {1'b1, 5'd6});
      @(negedge clk);
      chk("t4_opnd", {opnd_rs_data, opnd_rt_data}, {32'h66, 32'h66});
      chk("t4_reads", rd_count - base_rd, 2);
      res_valid = 1'b1; res_data = 32'h77; grant_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); res_valid = 1'b0;
         chk("t5_wr_stall", {sic_req_write, sic_addr, sic_wdata}, {1'b1, 5'd2, 32'h77});
         chk("t5_wr_ready", {res_ready, cmd_ready, done, sic_release}, 0);
      end
      grant_en = 1'b1;
      @(negedge clk);
      chk("t5_relwr", {sic_release, done, sic_addr}, {1'b1, 1'b1, 5'd2});
      chk("t5_wr_log", {last_wr_addr, last_wr_data}, {5'd2, 32'h77});
      @(negedge clk);
      chk("t5_idle", cmd_ready, 1);

      // Reset asserted in WR, then a fresh command
      grant_en = 1'b0;
      send_cmd(8'h55, 0, 5'd0, 0, 5'd0, 1, 5'd5);
      @(negedge clk); cmd_valid = 1'b0;
      chk("t6_wait", opnd_valid, 1);
      res_valid = 1'b1; res_data = 32'h55;
      @(negedge clk); res_valid = 1'b0;
      chk("t6_in_wr", {sic_req_write, sic_addr}, {1'b1, 5'd5});
      base_rel = rel_count; base_wr = wr_count;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; grant_en = 1'b1;
      chk("t6_rst_ready", cmd_ready, 1);
      chk("t6_rst_outs", {opnd_valid, res_ready, done, sic_req_read, sic_req_write, sic_release}, 0);
      chk("t6_rst_buses", {sic_addr, sic_issue_id, sic_wdata}, 0);
      @(negedge clk);
      chk("t6_no_release", {rel_count - base_rel, wr_count - base_wr}, 0);
      send_cmd(8'h66, 1, 5'd3, 0, 5'd0, 1, 5'd8);
      @(negedge clk); cmd_valid = 1'b0;
      chk("t6_new_rd", {sic_req_read, sic_addr, sic_issue_id}, {1'b1, 5'd3, 8'h66});
      @(negedge clk);
      @(negedge clk);
      chk("t6_new_opnd", opnd_rs_data, 32'hA);
      res_valid = 1'b1; res_data = 32'h30;
      @(negedge clk); res_valid = 1'b0;
      chk("t6_new_wr", {sic_req_write, sic_addr, sic_wdata}, {1'b1, 5'd8, 32'h30});
      @(negedge clk);
      chk("t6_new_done", {done, sic_release}, 2'b11);
      chk("t6_new_log", {last_wr_addr, last_wr_data}, {5'd8, 32'h30});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sic_reg_sequencer.md
# sic_reg_sequencer

Per-SIC operand/result sequencer sitting between one single-instruction controller and its port on the locked register file (`register_module`). It accepts one decoded command (up to two source registers, one destination, an issue ID) and reads each source under lock with ordered release. It then presents operands, waits for the execution result, writes the destination under lock and releases it. One instance per SIC port; ports are driven strictly one register access at a time.

## Interface
- `NUM_PHY_REGS`, 32, number of physical registers; address width `AW = $clog2(NUM_PHY_REGS)`
- `ID_WIDTH`, 8, issue-ID width
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high; integration drives `register_module.rst_n` with `~rst`
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  sequencer in IDLE, can accept
- `cmd_issue_id`  in  ID_WIDTH  issue ID of the instruction
- `cmd_rs_en` / `cmd_rs_addr`  in  1 / AW  source 1 used / address
- `cmd_rt_en` / `cmd_rt_addr`  in  1 / AW  source 2 used / address
- `cmd_rd_en` / `cmd_rd_addr`  in  1 / AW  destination used / address
- `opnd_valid`  out  1  operands valid, held through WAIT_RES
- `opnd_rs_data`, `opnd_rt_data`  out  32  captured operands
- `res_valid`  in  1  execution result offered
- `res_data`  in  32  result value
- `res_ready`  out  1  high only in WAIT_RES
- `done`  out  1  one-cycle pulse when instruction retires from sequencer
- `sic_addr`  out  AW  register port address
- `sic_req_read`, `sic_req_write`  out  1  lock requests
- `sic_issue_id`  out  ID_WIDTH  latched issue ID
- `sic_release`  out  1  one-cycle lock release
- `sic_wdata`  out  32  write data
- `sic_rdata`  in  32  read data (valid only with grant and read request)
- `sic_grant`  in  1  lock grant for current request (combinational from register file)

## Operation
- States: IDLE, RD_RS, REL_RS, RD_RT, REL_RT, WAIT_RES, WR, REL_WR.
- IDLE: `cmd_ready=1`; on `cmd_valid` latch all `cmd_*`; next state = first required of RD_RS, RD_RT, WAIT_RES.
- Register 0 is hard zero: source with addr 0 is treated as enabled-but-free (operand = 0, no request); destination addr 0 treated as `cmd_rd_en=0`.
- Disabled sources yield operand 0.
- RD_xx: drive `sic_addr`, `sic_req_read=1`; hold until `sic_grant`; in grant cycle capture `sic_rdata` and go to REL_xx. Never capture without grant.
- REL_xx: `sic_release=1`, same `sic_addr`, requests low; one cycle; then next required read or WAIT_RES.
- WAIT_RES: `opnd_valid=1`, `res_ready=1`; on `res_valid` latch `res_data`; go to WR if destination enabled, else IDLE with `done`.
- WR: `sic_req_write=1`, `sic_wdata` = latched result, hold until `sic_grant`; then REL_WR.
- REL_WR: `sic_release=1` one cycle; `done=1`; next IDLE.
- `sic_issue_id` = latched ID whenever any request or release is asserted.
- `sic_req_read` and `sic_req_write` are never both high; requests and release never coincide.
- rs and rt equal non-zero: read twice (two lock cycles), no bypass.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, all other outputs 0 (including data/address/ID buses).
- Reset mid-operation: abort to IDLE next cycle, no release emitted; register file is reset by the same signal.
- Best case, two reads, write, immediate grants: accept T; RD_RS T+1; REL_RS T+2; RD_RT T+3; REL_RT T+4; `opnd_valid` from T+5; `res_valid` at T+5 -> WR T+6, REL_WR/`done` T+7, `cmd_ready` T+8.
- No-source, no-dest command: accept T, WAIT_RES T+1; result at T+1 -> `done` at T+1, IDLE at T+2.
- Grant stall: request and address held unchanged indefinitely; no timeout.
- Command accepted only in IDLE; `cmd_valid` outside IDLE ignored.

## Structure
- Shared package `sic_pkg`: state enum `sic_seq_state_e`, constant `REG_ZERO_ADDR = 0`.
- Single module, one FSM plus latch registers; no sub-module.

## Test plan
- rs=3, rt=5, rd=7, id=0x12, grants immediate, regs hold 0xA/0xB, result 0x15 at T+5 -> operands 0xA/0xB at T+5, write 0x15 to 7 at T+6, release T+7, `done` T+7.
- rs=4 grant withheld 6 cycles -> `sic_req_read` and `sic_addr=4` held steady, no capture until grant, then normal flow.
- rs=0, rt=9, rd=0 -> no request for reg 0, `opnd_rs_data=0`, single read of 9, no write, `done` on result cycle.
- rs=rt=6 -> two separate read/release pairs to addr 6, both operands equal.
- `rst` asserted in WR -> next cycle IDLE, all outputs 0, no release; new command processed normally.
- Write grant stalled 4 cycles -> `sic_wdata` stable, `res_ready=0`, `cmd_ready=0` throughout.
